// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the logic unit and the ALU top that wraps it.
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_NOT  = 3'b010,
      OP_XOR  = 3'b011,
      OP_NAND = 3'b100,
      OP_NOR  = 3'b101,
      OP_SHL1 = 3'b110,
      OP_SHR1 = 3'b111
   } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Stateless logic operation and flag evaluation; shifts report the bit shifted out on flag_c.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic [OP_W-1:0] op,
   input  logic [BITS-1:0] in1,
   input  logic [BITS-1:0] in2,
   input  logic            sel,
   output logic [BITS-1:0] result,
   output logic            flag_n,
   output logic            flag_z,
   output logic            flag_v,
   output logic            flag_c
);

   logic [BITS-1:0] res_s;
   logic            carry_s;

   // Opcode decode and shifted-out bit
   always_comb begin
      res_s   = {BITS{1'b0}};
      carry_s = 1'b0;
      case (op_e'(op))
         OP_AND:  res_s = in1 & in2;
         OP_OR:   res_s = in1 | in2;
         OP_NOT: begin
            if (sel) begin
               res_s = ~in2;
            end else begin
               res_s = ~in1;
            end
         end
         OP_XOR:  res_s = in1 ^ in2;
         OP_NAND: res_s = ~(in1 & in2);
         OP_NOR:  res_s = ~(in1 | in2);
         OP_SHL1: begin
            res_s   = {in1[BITS-2:0], 1'b0};
            carry_s = in1[BITS-1];
         end
         OP_SHR1: begin
            res_s   = {1'b0, in1[BITS-1:1]};
            carry_s = in1[0];
         end
         default: begin
            res_s   = {BITS{1'b0}};
            carry_s = 1'b0;
         end
      endcase
   end

   assign result = res_s;
   assign flag_n = res_s[BITS-1];
   assign flag_z = (res_s == {BITS{1'b0}});
   assign flag_v = 1'b0;
   assign flag_c = carry_s;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic unit: S1 holds operands, S2 holds result and flags.
// The accumulator captures every S2 result so an acc=1 beat can chain on its predecessor.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [BITS-1:0] in1,
   input  logic [BITS-1:0] in2,
   input  logic            sel,
   input  logic            acc,
   input  logic            acc_clr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] result,
   output logic            flag_n,
   output logic            flag_z,
   output logic            flag_v,
   output logic            flag_c
);

   logic            s1_valid_r;
   logic [OP_W-1:0] s1_op_r;
   logic [BITS-1:0] s1_in1_r;
   logic [BITS-1:0] s1_in2_r;
   logic            s1_sel_r;
   logic            s1_acc_r;

   logic            s2_valid_r;
   logic [BITS-1:0] result_r;
   logic            flag_n_r;
   logic            flag_z_r;
   logic            flag_v_r;
   logic            flag_c_r;
   logic [BITS-1:0] acc_r;

   logic            s2_load_s;
   logic            s1_load_s;
   logic            in_ready_s;
   logic [BITS-1:0] core_in1_s;
   logic [BITS-1:0] core_result_s;
   logic            core_n_s;
   logic            core_z_s;
   logic            core_v_s;
   logic            core_c_s;

   // S1 drains exactly when S2 loads, so s2_load_s doubles as "S1 moves".
   assign s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
   assign in_ready_s = !s1_valid_r || s2_load_s;
   assign s1_load_s  = in_valid && in_ready_s;
   assign core_in1_s = s1_acc_r ? acc_r : s1_in1_r;

   logic_unit_core #(
      .BITS (BITS)
   ) u_core (
      .op     (s1_op_r),
      .in1    (core_in1_s),
      .in2    (s1_in2_r),
      .sel    (s1_sel_r),
      .result (core_result_s),
      .flag_n (core_n_s),
      .flag_z (core_z_s),
      .flag_v (core_v_s),
      .flag_c (core_c_s)
   );

   // Operand stage capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_op_r    <= {OP_W{1'b0}};
         s1_in1_r   <= {BITS{1'b0}};
         s1_in2_r   <= {BITS{1'b0}};
         s1_sel_r   <= 1'b0;
         s1_acc_r   <= 1'b0;
      end else if (s1_load_s) begin
         s1_valid_r <= 1'b1;
         s1_op_r    <= op;
         s1_in1_r   <= in1;
         s1_in2_r   <= in2;
         s1_sel_r   <= sel;
         s1_acc_r   <= acc;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Result stage capture and drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         result_r   <= {BITS{1'b0}};
         flag_n_r   <= 1'b0;
         flag_z_r   <= 1'b0;
         flag_v_r   <= 1'b0;
         flag_c_r   <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= 1'b1;
         result_r   <= core_result_s;
         flag_n_r   <= core_n_s;
         flag_z_r   <= core_z_s;
         flag_v_r   <= core_v_s;
         flag_c_r   <= core_c_s;
      end else if (out_ready) begin
         s2_valid_r <= 1'b0;
      end
   end

   // Accumulator: clear has priority over a coinciding S2 load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {BITS{1'b0}};
      end else if (acc_clr) begin
         acc_r <= {BITS{1'b0}};
      end else if (s2_load_s) begin
         acc_r <= core_result_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = s2_valid_r;
   assign result    = result_r;
   assign flag_n    = flag_n_r;
   assign flag_z    = flag_z_r;
   assign flag_v    = flag_v_r;
   assign flag_c    = flag_c_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks of logic_unit_pipe against an arithmetic reference model.
module tb_logic_unit_pipe;

   localparam int BITS = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [BITS-1:0] in1;
   logic [BITS-1:0] in2;
   logic            sel;
   logic            acc;
   logic            acc_clr;
   logic            out_valid;
   logic            out_ready;
   logic [BITS-1:0] result;
   logic            flag_n;
   logic            flag_z;
   logic            flag_v;
   logic            flag_c;

   typedef struct {
      logic [7:0] res;
      logic       n;
      logic       z;
      logic       c;
   } exp_t;

   exp_t       q[$];
   logic [7:0] model_acc;
   logic       held_valid;
   logic [7:0] held_res;
   int         checks   = 0;
   int         failures = 0;
   int         accepted = 0;
   int         popped   = 0;

   logic_unit_pipe #(.BITS(BITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .sel       (sel),
      .acc       (acc),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_v    (flag_v),
      .flag_c    (flag_c)
   );

   always #5 clk = ~clk;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Reference: plain arithmetic on unsigned values in 0..255
   function automatic exp_t model(input logic [2:0] o, input int a, input int b, input logic s);
      exp_t e;
      int   r;
      int   c;
      c = 0;
      case (o)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = 255 - (s ? b : a);
         3'd3: r = a ^ b;
         3'd4: r = 255 - (a & b);
         3'd5: r = 255 - (a | b);
         3'd6: begin r = (a * 2) % 256; c = a / 128; end
         default: begin r = a / 2; c = a % 2; end
      endcase
      e.res = r[7:0];
      e.n   = (r >= 128);
      e.z   = (r == 0);
      e.c   = c[0];
      return e;
   endfunction

   // One cycle of scoreboarded traffic; called at a negedge with inputs already driven.
   task automatic step(input string tag);
      exp_t e;
      int   a;
      #1;
      if (held_valid) begin
         chk1({tag, " hold_valid"}, out_valid, 1'b1);
         chk8({tag, " hold_result"}, result, held_res);
      end
      if (out_valid && out_ready) begin
         chk1({tag, " pop_nonempty"}, q.size() > 0, 1'b1);
         if (q.size() > 0) begin
            e = q.pop_front();
            popped++;
            chk8({tag, " result"}, result, e.res);
            chk1({tag, " flag_n"}, flag_n, e.n);
            chk1({tag, " flag_z"}, flag_z, e.z);
            chk1({tag, " flag_c"}, flag_c, e.c);
            chk1({tag, " flag_v"}, flag_v, 1'b0);
         end
      end
      held_valid = out_valid && !out_ready;
      held_res   = result;
      if (in_valid && in_ready) begin
         a = acc ? int'(model_acc) : int'(in1);
         e = model(op, a, int'(in2), sel);
         model_acc = e.res;
         q.push_back(e);
         accepted++;
         chk1({tag, " in_flight_le2"}, q.size() <= 2, 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Single beat with no backpressure: out_valid shows up after the second edge.
   task automatic beat(input string tag, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic s, input logic ac,
                       input logic [7:0] er, input logic en, input logic ez, input logic ec);
      in_valid = 1'b1; op = o; in1 = a; in2 = b; sel = s; acc = ac; out_ready = 1'b1;
      #1;
      chk1({tag, " in_ready"}, in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk1({tag, " out_valid_edge1"}, out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk1({tag, " out_valid_edge2"}, out_valid, 1'b1);
      chk8({tag, " result"}, result, er);
      chk1({tag, " flag_n"}, flag_n, en);
      chk1({tag, " flag_z"}, flag_z, ez);
      chk1({tag, " flag_c"}, flag_c, ec);
      chk1({tag, " flag_v"}, flag_v, 1'b0);
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [2:0] st_op  [4] = '{3'd0, 3'd1, 3'd3, 3'd7};
   logic [7:0] st_in1 [4] = '{8'hA5, 8'h50, 8'hFF, 8'h80};
   logic [7:0] st_in2 [4] = '{8'h0F, 8'h0A, 8'h0F, 8'h00};

   initial begin
      int idx;
      rst = 1'b1; in_valid = 1'b0; op = 3'd0; in1 = 8'h00; in2 = 8'h00;
      sel = 1'b0; acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
      model_acc = 8'h00; held_valid = 1'b0; held_res = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk1("rst out_valid", out_valid, 1'b0);
      chk1("rst in_ready", in_ready, 1'b1);
      chk8("rst result", result, 8'h00);
      chk1("rst flag_n", flag_n, 1'b0);
      chk1("rst flag_z", flag_z, 1'b0);
      chk1("rst flag_c", flag_c, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic ops and shift/NOT boundaries
      beat("and",  3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
      beat("shl1", 3'd6, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
      beat("shr1", 3'd7, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      beat("not2", 3'd2, 8'h00, 8'h0F, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
      beat("nor",  3'd5, 8'h12, 8'h40, 1'b0, 1'b0, 8'hAD, 1'b1, 1'b0, 1'b0);

      // Back-to-back chaining through the accumulator
      in_valid = 1'b1; op = 3'd3; in1 = 8'h00; in2 = 8'hFF; acc = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in1 = 8'h5A; in2 = 8'h0F; acc = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; acc = 1'b0;
      #1;
      chk1("chain_a valid", out_valid, 1'b1);
      chk8("chain_a result", result, 8'hFF);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk1("chain_b valid", out_valid, 1'b1);
      chk8("chain_b result", result, 8'hF0);
      @(posedge clk);
      @(negedge clk);
      acc_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      acc_clr = 1'b0;
      beat("after_clr", 3'd1, 8'hAA, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

      // Clear coinciding with an S2 load wins, the beat itself is unaffected
      in_valid = 1'b1; op = 3'd0; in1 = 8'hFF; in2 = 8'hAA; acc = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; acc_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      acc_clr = 1'b0;
      #1;
      chk8("clr_coincide result", result, 8'hAA);
      @(posedge clk);
      @(negedge clk);
      beat("clr_win", 3'd1, 8'h55, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      model_acc = 8'h00;

      // Backpressure: 4 beats offered, downstream stalled for 5 cycles
      idx = 0;
      accepted = 0;
      popped = 0;
      out_ready = 1'b0;
      acc = 1'b0;
      sel = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idx = accepted;
         in_valid = (idx < 4);
         if (idx < 4) begin op = st_op[idx]; in1 = st_in1[idx]; in2 = st_in2[idx]; end
         step("stall");
      end
      #1;
      chk8("stall accepted", 8'(accepted), 8'd2);
      chk1("stall in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (popped < 4 || accepted < 4); i++) begin
         idx = accepted;
         in_valid = (idx < 4);
         if (idx < 4) begin op = st_op[idx]; in1 = st_in1[idx]; in2 = st_in2[idx]; end
         step("release");
      end
      in_valid = 1'b0;
      chk8("release popped", 8'(popped), 8'd4);

      // Reset with two beats in flight
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd1; in1 = 8'h11; in2 = 8'h22;
      step("pre_rst");
      in1 = 8'h33;
      step("pre_rst");
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk1("midrst out_valid", out_valid, 1'b0);
      chk8("midrst result", result, 8'h00);
      chk1("midrst in_ready", in_ready, 1'b1);
      q.delete();
      model_acc = 8'h00;
      held_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk1("post_rst no_stale", out_valid, 1'b0);
         step("post_rst");
      end

      // Randomized traffic with random backpressure and chaining
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         op        = 3'($urandom_range(0, 7));
         in1       = 8'($urandom_range(0, 255));
         in2       = 8'($urandom_range(0, 255));
         sel       = 1'($urandom_range(0, 1));
         acc       = 1'($urandom_range(0, 1));
         step("rand");
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         step("drain");
      end
      chk8("drain empty", 8'(q.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have parameter BITS, default 8, giving the operand/result width (legal >= 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 op  input  3  operation select per REQ-015.
REQ-008 in1, in2  input  BITS  operands.
REQ-009 sel  input  1  NOT operand select: 0 inverts in1, 1 inverts in2.
REQ-010 acc  input  1  when 1, the accumulator replaces in1 for this beat.
REQ-011 acc_clr  input  1  synchronous clear of the accumulator.
REQ-012 out_valid  output  1  result beat held.
REQ-013 out_ready  input  1  downstream consumes the beat.
REQ-014 result  output  BITS; flag_n, flag_z, flag_v, flag_c  output  1 each  registered result and flags.

Function
REQ-015 Opcodes SHALL be: 000 AND, 001 OR, 010 NOT (operand per sel), 011 XOR, 100 NAND, 101 NOR, 110 SHL1 of in1 (zero fill), 111 SHR1 of in1 (logical, zero fill).
REQ-016 The datapath SHALL be a two-stage pipeline: S1 registers op/in1/in2/sel/acc; S2 computes from S1 contents and registers result plus flags.
REQ-017 A beat SHALL transfer on in_valid && in_ready; a beat SHALL leave on out_valid && out_ready.
REQ-018 With no backpressure, latency SHALL be 2 cycles from the input handshake edge to out_valid, at 1 beat/cycle throughput.
REQ-019 S2 SHALL load when S1 is valid and (S2 empty or out_ready=1); S1 SHALL load when in_valid and (S1 empty or S1 moves to S2 this cycle).
REQ-020 in_ready SHALL equal !s1_valid || s1_moves (combinational, no dependence on in_valid).
REQ-021 With out_ready=0, S2 and its outputs SHALL hold stable; at most 2 beats SHALL be in flight; no beat SHALL be dropped or duplicated.
REQ-022 flag_n SHALL equal result[BITS-1]; flag_z SHALL be 1 iff result is all zero; flag_v SHALL always be 0.
REQ-023 flag_c SHALL be the bit shifted out: in1[BITS-1] for SHL1, in1[0] for SHR1, 0 for all other ops.
REQ-024 The accumulator (BITS wide) SHALL load each result as S2 captures it; with acc=1, the S2 computation SHALL use the accumulator value in place of in1, allowing back-to-back chaining.
REQ-025 acc_clr SHALL zero the accumulator at the edge; if acc_clr and an S2 load coincide, the clear SHALL win; acc_clr SHALL NOT affect beats in flight except through the accumulator value.

Reset
REQ-026 While rst=1: S1/S2 valid bits, result, all flags, and the accumulator SHALL be 0; out_valid=0; in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats; no beat SHALL emerge after release unless newly accepted.

Structure
REQ-028 The opcode constants (OP_AND .. OP_SHR1) SHALL live in a shared package used by this block and by the ALU top.
REQ-029 The combinational op/flag evaluation SHALL be one sub-module, logic_unit_core (BITS-parameterised, no state); the pipeline and accumulator SHALL reside in logic_unit_pipe.

Verification (BITS=8)
REQ-030 Reset then one beat: op=000, in1=0xF0, in2=0x3C, out_ready=1 -> result=0x30, N=0, Z=0, C=0, out_valid exactly 2 cycles after the handshake edge.
REQ-031 SHL1 in1=0x81 -> result=0x02, C=1; SHR1 in1=0x01 -> result=0x00, Z=1, C=1; NOT sel=1, in2=0x0F -> 0xF0, N=1.
REQ-032 Stream of 4 beats with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted beats, result holds; release -> all 4 beats appear in order, none lost.
REQ-033 Chaining: beat A XOR 0x00^0xFF, then beat B acc=1, XOR in2=0x0F, back-to-back -> results 0xFF then 0xF0; acc_clr then acc=1, OR in2=0x00 -> 0x00, Z=1.
REQ-034 Assert rst while 2 beats are in flight -> out_valid=0 and result=0 immediately, in_ready=1; no stale beat after release.
